// File: rtl/freq_pkg.sv
// freq_pkg: shared definitions for the frequency-measurement scheduler.
//   state_t            FSM state encoding (S_IDLE .. S_REPORT)
//   DEF_GATE_CYCLES    default gate window length in clk cycles
//   DEF_SETTLE_CYCLES  default synchronizer settle time after a channel switch
//   clog2()            constant ceil(log2) for sizing counters
package freq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_GATE,
    S_REPORT
  } state_t;

  localparam int DEF_GATE_CYCLES   = 1000;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_edge_cnt.sv
// freq_edge_cnt: rising-edge counter for an already-synchronized input.
//   clk, rst_n  clock, async active-low reset
//   clr         clear count and overflow flag (takes priority over en)
//   en          count rising edges of din this cycle
//   din         synchronized input bit
//   count       saturating edge count
//   ovf         set when an increment was attempted at saturation
// prev follows din on every cycle, so holding clr for at least one cycle
// also primes the edge detector with the current input level.
module freq_edge_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      prev <= din;
      if (clr) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (en && din && !prev) begin
        if (count == {CNT_W{1'b1}}) ovf <= 1'b1;
        else                        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin frequency measurement over NCH async inputs
// with a single shared edge counter.
//   clk, rst_n   clock, async active-low reset
//   en           run enable
//   ch_mask      per-channel enable, sampled when the next channel is chosen
//   in           asynchronous inputs under measurement
//   freq         edge count of the last completed gate window
//   freq_ch      channel that freq belongs to
//   freq_ovf     count saturated during that window
//   freq_valid   result available (valid/ready handshake with freq_ready)
//   freq_ready   consumer accepts the result
//   busy         scheduler is not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for en with a non-empty channel mask
// S_SELECT | advance pointer to next enabled channel (1 cycle)
// S_SETTLE | flush sync path of new channel, clear counter, prime prev
// S_GATE   | count rising edges for GATE_CYCLES cycles
// S_REPORT | latch result (first cycle), then hold valid until accepted
module freq_meas_sched
  import freq_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int CHW           = 2,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [NCH-1:0]   in,
  output logic [CNT_W-1:0] freq,
  output logic [CHW-1:0]   freq_ch,
  output logic             freq_ovf,
  output logic             freq_valid,
  input  logic             freq_ready,
  output logic             busy
);

  localparam int GW = clog2(GATE_CYCLES + 1);
  localparam int SW = clog2(SETTLE_CYCLES + 1);

  state_t           state;
  logic [CHW-1:0]   ptr;
  logic [SW-1:0]    settle_cnt;
  logic [GW-1:0]    gate_cnt;
  logic [NCH-1:0]   sync1, sync2;
  logic             sel_bit;
  logic [CNT_W-1:0] count;
  logic             ovf;

  // Next enabled channel strictly after cur, wrapping. Scanning the offsets
  // from farthest to nearest lets the nearest hit overwrite the others.
  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] cur,
                                             input logic [NCH-1:0] mask);
    logic [CHW-1:0] res;
    int idx;
    res = cur;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(cur) + k) % NCH;
      if (mask[idx]) res = CHW'(idx);
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  assign sel_bit = sync2[ptr];

  freq_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == S_SETTLE),
    .en    (state == S_GATE),
    .din   (sel_bit),
    .count (count),
    .ovf   (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= CHW'(NCH - 1);
      settle_cnt <= '0;
      gate_cnt   <= '0;
      freq       <= '0;
      freq_ch    <= '0;
      freq_ovf   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && (ch_mask != '0)) state <= S_SELECT;
        end
        S_SELECT: begin
          if (!en || (ch_mask == '0)) begin
            state <= S_IDLE;
          end else begin
            ptr        <= next_ch(ptr, ch_mask);
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (settle_cnt == '0) begin
            gate_cnt <= '0;
            state    <= S_GATE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_GATE: begin
          if (!en)                                  state <= S_IDLE;
          else if (gate_cnt == GW'(GATE_CYCLES - 1)) state <= S_REPORT;
          else                                      gate_cnt <= gate_cnt + 1'b1;
        end
        S_REPORT: begin
          // The counter absorbs the last gate cycle on the REPORT entry edge,
          // so the result is latched one cycle later.
          if (!freq_valid) begin
            freq       <= count;
            freq_ch    <= ptr;
            freq_ovf   <= ovf;
            freq_valid <= 1'b1;
          end else if (freq_ready) begin
            freq_valid <= 1'b0;
            state      <= en ? S_SELECT : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_freq_meas_sched.sv
module tb_freq_meas_sched;
  localparam int NCH = 4, CHW = 2, G = 100, S = 2, CNT_W = 8, G2 = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0, rst2_n = 1'b0;
  logic en = 1'b0, freq_ready = 1'b0;
  logic [NCH-1:0] ch_mask = '0, in_sig = '0, in2 = '0;
  logic [CNT_W-1:0] freq, freq2;
  logic [CHW-1:0] freq_ch, freq_ch2;
  logic freq_ovf, freq_valid, busy, freq_ovf2, freq_valid2, busy2;

  freq_meas_sched #(.NCH(NCH), .CHW(CHW), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .in(in_sig),
    .freq(freq), .freq_ch(freq_ch), .freq_ovf(freq_ovf), .freq_valid(freq_valid),
    .freq_ready(freq_ready), .busy(busy));

  freq_meas_sched #(.NCH(NCH), .CHW(CHW), .GATE_CYCLES(G2), .SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut_ovf (
    .clk(clk), .rst_n(rst2_n), .en(1'b1), .ch_mask(4'b0001), .in(in2),
    .freq(freq2), .freq_ch(freq_ch2), .freq_ovf(freq_ovf2), .freq_valid(freq_valid2),
    .freq_ready(1'b1), .busy(busy2));

  always #5 clk = ~clk;

  typedef struct { int ch; int f; int ovf; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, xfer_cnt = 0, exp_total = 0, ptr_m = NCH - 1;
  int xfer_cyc[$];
  int per[NCH] = '{10, 20, 25, 50};
  int hi[NCH], ph[NCH];
  int divs[8] = '{2, 4, 5, 10, 20, 25, 50, 100};
  bit done2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Periodic inputs whose period divides G: every G-cycle window holds exactly G/per edges.
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) in_sig[c] = (((cyc + ph[c]) % per[c]) < hi[c]);
      in2[0] = ~in2[0];
    end
  end

  // Reference model: next enabled channel after p, and expected reading for a channel.
  function automatic int nxt(input int p, input logic [NCH-1:0] m);
    for (int k = 1; k <= NCH; k++) if (m[(p + k) % NCH]) return (p + k) % NCH;
    return p;
  endfunction

  task automatic push_exp(input int c);
    exp_t e;
    int edges;
    edges = G / per[c];
    e.ch = c;
    e.f = (edges > 255) ? 255 : edges;
    e.ovf = (edges > 255) ? 1 : 0;
    q.push_back(e);
    exp_total++;
  endtask

  // Monitor: pops the scoreboard on each transfer; checks outputs hold while stalled.
  initial begin
    bit prev_hold;
    int hf, hc, ho;
    exp_t e;
    prev_hold = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n || !freq_valid) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          check("hold_freq", int'(freq), hf);
          check("hold_ch", int'(freq_ch), hc);
          check("hold_ovf", int'(freq_ovf), ho);
        end
        if (freq_ready) begin
          xfer_cnt++;
          xfer_cyc.push_back(cyc);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result ch=%0d freq=%0d, none was expected", freq_ch, freq);
          end else begin
            e = q.pop_front();
            check("res_ch", int'(freq_ch), e.ch);
            check("res_freq", int'(freq), e.f);
            check("res_ovf", int'(freq_ovf), e.ovf);
          end
        end
        prev_hold = !freq_ready;
        hf = int'(freq); hc = int'(freq_ch); ho = int'(freq_ovf);
      end
    end
  end

  task automatic wait_xfer(input bit rnd);
    int n, budget;
    n = 0;
    budget = 400 * (exp_total - xfer_cnt) + 50;
    while (xfer_cnt < exp_total && n < budget) begin
      @(negedge clk);
      if (rnd) freq_ready = 1'($urandom % 2);
      n++;
    end
    check("xfer_reached", (xfer_cnt >= exp_total) ? 1 : 0, 1);
  endtask

  task automatic expect_n(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      ptr_m = nxt(ptr_m, ch_mask);
      push_exp(ptr_m);
    end
    wait_xfer(rnd);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!freq_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("valid_reached", int'(freq_valid), 1);
  endtask

  // Saturation: 500 edges into an 8-bit counter.
  initial begin
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    rst2_n = 1'b1;
    while (!freq_valid2 && n < G2 + 200) begin
      @(negedge clk);
      n++;
    end
    check("ovf_valid", int'(freq_valid2), 1);
    check("ovf_freq", int'(freq2), 255);
    check("ovf_flag", int'(freq_ovf2), 1);
    check("ovf_ch", int'(freq_ch2), 0);
    done2 = 1'b1;
  end

  initial begin
    int xb, n;
    per[2] = divs[$urandom_range(0, 7)];
    for (int c = 0; c < NCH; c++) begin
      hi[c] = $urandom_range(1, per[c] - 1);
      ph[c] = $urandom_range(0, per[c] - 1);
    end
    repeat (3) @(negedge clk);
    check("rst_freq", int'(freq), 0);
    check("rst_ch", int'(freq_ch), 0);
    check("rst_ovf", int'(freq_ovf), 0);
    check("rst_valid", int'(freq_valid), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_empty_mask_busy", int'(busy), 0);

    // Single channel, ready held high: fixed result cadence.
    ch_mask = 4'b0001;
    freq_ready = 1'b1;
    expect_n(3, 0);
    check("valid_period_a", xfer_cyc[1] - xfer_cyc[0], G + S + 3);
    check("valid_period_b", xfer_cyc[2] - xfer_cyc[1], G + S + 3);

    // Mask 1011: channel 2 must be skipped.
    ch_mask = 4'b1011;
    expect_n(4, 0);

    // Random masks with random backpressure.
    for (int r = 0; r < 4; r++) begin
      ch_mask = 4'($urandom_range(1, 15));
      expect_n($urandom_range(1, 3), 1);
    end
    freq_ready = 1'b1;

    // Stall 50 cycles; mask change while stalled only affects the next selection.
    freq_ready = 1'b0;
    ptr_m = nxt(ptr_m, ch_mask);
    push_exp(ptr_m);
    wait_valid();
    xb = xfer_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) ch_mask = 4'b0100;
    end
    check("stall_no_xfer", xfer_cnt, xb);
    check("stall_busy", int'(busy), 1);
    check("stall_valid", int'(freq_valid), 1);
    ptr_m = nxt(ptr_m, ch_mask);
    push_exp(ptr_m);
    freq_ready = 1'b1;
    wait_xfer(0);

    // Abort in the gate window: no result, idle within 2 cycles, rotation continues.
    ch_mask = 4'b1111;
    ptr_m = nxt(ptr_m, ch_mask);
    repeat (45) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", int'(busy), 0);
    xb = xfer_cnt;
    repeat (150) @(negedge clk);
    check("abort_no_xfer", xfer_cnt, xb);
    check("abort_valid", int'(freq_valid), 0);
    en = 1'b1;
    expect_n(2, 0);

    // en dropped while a result is pending: handshake completes, then idle.
    freq_ready = 1'b0;
    ptr_m = nxt(ptr_m, ch_mask);
    push_exp(ptr_m);
    wait_valid();
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("report_en_low_busy", int'(busy), 1);
    freq_ready = 1'b1;
    wait_xfer(0);
    repeat (2) @(negedge clk);
    check("report_en_low_idle", int'(busy), 0);

    // Mask emptied before the next selection: back to idle.
    en = 1'b1;
    freq_ready = 1'b0;
    ptr_m = nxt(ptr_m, ch_mask);
    push_exp(ptr_m);
    wait_valid();
    ch_mask = 4'b0000;
    freq_ready = 1'b1;
    wait_xfer(0);
    repeat (3) @(negedge clk);
    check("empty_mask_idle", int'(busy), 0);

    // Asynchronous reset in the middle of a gate window.
    ch_mask = 4'b0001;
    repeat (60) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_freq", int'(freq), 0);
    check("arst_ch", int'(freq_ch), 0);
    check("arst_ovf", int'(freq_ovf), 0);
    check("arst_valid", int'(freq_valid), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = NCH - 1;
    ch_mask = 4'b0000;
    repeat (20) @(negedge clk);
    check("post_reset_idle_busy", int'(busy), 0);
    check("post_reset_idle_valid", int'(freq_valid), 0);
    ch_mask = 4'b1111;
    expect_n(2, 0);

    n = 0;
    while (!done2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ovf_instance_done", int'(done2), 1);
    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meas_sched.md
Name: freq_meas_sched

Overview:
- Multi-channel frequency-measurement scheduler. One edge counter is shared round-robin across NCH asynchronous input signals.
- Per channel, it sequences: select channel, settle the synchronizer, open a gate window of GATE_CYCLES clocks, count rising edges, then hand the result off.
- Sits between the raw test/sense inputs and the display/host logic that consumes 8-bit frequency readings.

Parameters:
- NCH, 4, number of input channels (2..16).
- CHW, 2, channel index width; must equal clog2(NCH).
- GATE_CYCLES, 1000, gate window length in CLK cycles (1000 at 1 kHz CLK gives a 1 s window, so result = Hz).
- SETTLE_CYCLES, 2, discard cycles after a channel switch (at least 1).
- CNT_W, 8, result width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  run enable.
- CH_MASK  in  NCH  per-channel enable; sampled only at channel selection.
- IN  in  NCH  asynchronous signals under measurement.
- FREQ  out  CNT_W  edge count of the last completed window.
- FREQ_CH  out  CHW  channel that FREQ belongs to.
- FREQ_OVF  out  1  count saturated during the window.
- FREQ_VALID  out  1  result available.
- FREQ_READY  in  1  consumer accepts the result.
- BUSY  out  1  state is not IDLE.

Behaviour:
- Reset (async, RST_N low): state IDLE; FREQ=0; FREQ_CH=0; FREQ_OVF=0; FREQ_VALID=0; BUSY=0; all synchronizer flops 0; current channel pointer = NCH-1, so the first search starts at channel 0.
- Synchronizer: every channel passes through a 2-flop sync that runs continuously. The edge detector uses the selected synced bit and a prev register.
- FSM states: IDLE, SELECT, SETTLE, GATE, REPORT.
- IDLE:
  - Go to SELECT when EN=1 and CH_MASK != 0.
  - Otherwise hold.
- SELECT (1 cycle):
  - Pointer becomes the next set bit of CH_MASK strictly after the current pointer, wrapping modulo NCH.
  - A single-channel mask reselects the same channel.
  - If the mask became 0, return to IDLE.
- SETTLE (SETTLE_CYCLES cycles):
  - Load prev from the selected synced bit every cycle.
  - Clear the edge counter and OVF accumulator.
  - No counting.
- GATE (exactly GATE_CYCLES cycles):
  - Each cycle, if synced=1 and prev=0, increment the counter.
  - The counter saturates at 2^CNT_W-1. An increment attempted at saturation sets the OVF accumulator.
  - prev updates every cycle.
  - The gate counter runs from 0 to GATE_CYCLES-1, then the FSM goes to REPORT.
- REPORT:
  - On entry (1 cycle after the last gate cycle), register FREQ, FREQ_CH and FREQ_OVF, and set FREQ_VALID=1.
  - Outputs stay stable while VALID=1 and READY=0.
  - A transfer occurs on a cycle with VALID=1 and READY=1. The next cycle has VALID=0 and the FSM goes to SELECT, or to IDLE if EN=0.
  - READY held high gives one result per GATE_CYCLES+SETTLE_CYCLES+3 cycles.
  - FREQ retains its last value after VALID drops.
- EN deasserted:
  - In SELECT/SETTLE/GATE: abort to IDLE next cycle. The partial count is discarded and no VALID is produced.
  - In REPORT: the handshake completes first, then IDLE.
- CH_MASK changes during SETTLE/GATE/REPORT do not affect the in-flight measurement. They take effect at the next SELECT.
- An edge that arrives exactly at the SETTLE-to-GATE boundary is not counted, because prev is already loaded.
- Async reset mid-operation returns everything to reset values immediately, with no partial result.
- Gate counter width: clog2(GATE_CYCLES+1).

Decomposition:
- Shared package freq_pkg:
  - FSM state encoding constants (S_IDLE..S_REPORT).
  - Default GATE_CYCLES/SETTLE_CYCLES.
  - clog2 constant function.
- One natural sub-module, freq_edge_cnt: a synced-input rising-edge counter with clear, enable and saturation/OVF. The scheduler instantiates it once and feeds it the muxed channel.
- Channel search (next set bit after pointer with wrap) is a combinational function inside the scheduler.

Test Plan:
- GATE_CYCLES=100, SETTLE_CYCLES=2, CH_MASK=4'b0001, IN[0] toggling every 5 CLK (period 10), READY=1 -> FREQ=10, FREQ_CH=0, FREQ_OVF=0; VALID pulses once every 105 cycles.
- CH_MASK=4'b1011, channels 0/1/3 at periods 10/20/50, READY=1 -> FREQ_CH sequence 0,1,3,0 with FREQ 10,5,2,10; channel 2 never reported.
- GATE_CYCLES=1000, IN[0] period 2 (500 edges) -> FREQ=255, FREQ_OVF=1.
- READY held 0 for 50 cycles after VALID -> FREQ/FREQ_CH/VALID stable for all 50 cycles; FSM stays in REPORT; next channel starts only after the READY=1 transfer.
- EN dropped at gate cycle 40 -> no VALID, BUSY=0 within 2 cycles; re-enable -> measurement restarts at the next channel in the rotation.
- RST_N pulsed low mid-GATE, asynchronously between clock edges -> all outputs 0 immediately; CH_MASK=0 afterwards with EN=1 -> FSM stays in IDLE, BUSY=0.
